// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - grid cursor controller with hold-delay auto-repeat and select/back pulses
module cursor_ctrl #(
  parameter int N_ROWS    = 8,
  parameter int N_COLS    = 16,
  parameter int DELAY_CYC = 50000000,
  parameter int RATE_CYC  = 10000000,
  parameter int WRAP      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      up,
  input  logic                      down,
  input  logic                      left,
  input  logic                      right,
  input  logic                      a,
  input  logic                      b,
  output logic [$clog2(N_ROWS)-1:0] row,
  output logic [$clog2(N_COLS)-1:0] col,
  output logic                      move_tick,
  output logic                      sel_tick,
  output logic                      back_tick,
  output logic                      repeating
);

  localparam int RW      = $clog2(N_ROWS);
  localparam int CLW     = $clog2(N_COLS);
  localparam int CNT_MAX = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [RW-1:0]  ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(N_COLS - 1);
  localparam logic [CW-1:0]  DELAY_LD = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0]  RATE_LD  = CW'(RATE_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t        state;
  dir_t          dir;
  logic [CW-1:0] cnt;

  logic up_q, down_q, left_q, right_q, a_q, b_q, a_p, b_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      a_p       <= 1'b0;
      b_p       <= 1'b0;
      sel_tick  <= 1'b0;
      back_tick <= 1'b0;
    end else begin
      up_q      <= up;
      down_q    <= down;
      left_q    <= left;
      right_q   <= right;
      a_q       <= a;
      b_q       <= b;
      a_p       <= a_q;
      b_p       <= b_q;
      sel_tick  <= a_q & ~a_p;
      back_tick <= b_q & ~b_p;
    end
  end

  logic           any_key;
  logic           held;
  dir_t           pick;
  dir_t           step_dir;
  logic [RW-1:0]  step_row;
  logic [CLW-1:0] step_col;
  logic           moved;

  assign any_key = up_q | down_q | left_q | right_q;

  always_comb begin
    pick = DIR_RIGHT;
    if (up_q)        pick = DIR_UP;
    else if (down_q) pick = DIR_DOWN;
    else if (left_q) pick = DIR_LEFT;
  end

  always_comb begin
    held = 1'b0;
    case (dir)
      DIR_UP:    held = up_q;
      DIR_DOWN:  held = down_q;
      DIR_LEFT:  held = left_q;
      DIR_RIGHT: held = right_q;
      default:   held = 1'b0;
    endcase
  end

  // IDLE steps in the freshly picked direction; HOLD/REPEAT reuse the captured one.
  assign step_dir = (state == IDLE) ? pick : dir;

  always_comb begin
    step_row = row;
    step_col = col;
    case (step_dir)
      DIR_UP: begin
        if (row != '0)    step_row = row - 1'b1;
        else if (WRAP != 0) step_row = ROW_LAST;
      end
      DIR_DOWN: begin
        if (row != ROW_LAST) step_row = row + 1'b1;
        else if (WRAP != 0)  step_row = '0;
      end
      DIR_LEFT: begin
        if (col != '0)    step_col = col - 1'b1;
        else if (WRAP != 0) step_col = COL_LAST;
      end
      DIR_RIGHT: begin
        if (col != COL_LAST) step_col = col + 1'b1;
        else if (WRAP != 0)  step_col = '0;
      end
      default: begin
        step_row = row;
        step_col = col;
      end
    endcase
    moved = (step_row != row) || (step_col != col);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      move_tick <= 1'b0;
      repeating <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (any_key) begin
            dir       <= pick;
            row       <= step_row;
            col       <= step_col;
            move_tick <= moved;
            cnt       <= DELAY_LD;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!held) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            row       <= step_row;
            col       <= step_col;
            move_tick <= moved;
            cnt       <= RATE_LD;
            state     <= REPEAT;
            repeating <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REPEAT: begin
          if (!held) begin
            state     <= IDLE;
            repeating <= 1'b0;
          end else if (cnt == '0) begin
            row       <= step_row;
            col       <= step_col;
            move_tick <= moved;
            cnt       <= RATE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb/tb_cursor_ctrl.sv - table-driven and directed-sequence bench for cursor_ctrl (3x5 grid, delay 8, rate 3)
module tb_cursor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, a = 1'b0, b = 1'b0;
  logic [1:0] row, row_s;
  logic [2:0] col, col_s;
  logic       move_tick, sel_tick, back_tick, repeating;
  logic       move_s, sel_s, back_s, rep_s;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cursor_ctrl #(.N_ROWS(3), .N_COLS(5), .DELAY_CYC(8), .RATE_CYC(3), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .a(a), .b(b), .row(row), .col(col), .move_tick(move_tick),
    .sel_tick(sel_tick), .back_tick(back_tick), .repeating(repeating)
  );

  cursor_ctrl #(.N_ROWS(3), .N_COLS(5), .DELAY_CYC(8), .RATE_CYC(3), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .a(a), .b(b), .row(row_s), .col(col_s), .move_tick(move_s),
    .sel_tick(sel_s), .back_tick(back_s), .repeating(rep_s)
  );

  localparam logic [5:0] K_NONE = 6'b000000;
  localparam logic [5:0] K_UP   = 6'b100000;
  localparam logic [5:0] K_DN   = 6'b010000;
  localparam logic [5:0] K_LF   = 6'b001000;
  localparam logic [5:0] K_RT   = 6'b000100;
  localparam logic [5:0] K_A    = 6'b000010;
  localparam logic [5:0] K_B    = 6'b000001;

  typedef struct {
    logic [5:0] in;
    logic [1:0] row;
    logic [2:0] col;
    logic       mv;
    logic       sel;
    logic       bk;
    logic       rep;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic [5:0] in, input int r, input int c,
                     input logic mv, input logic sel, input logic bk, input logic rep);
    vec_t v;
    v.in  = in;
    v.row = 2'(r);
    v.col = 3'(c);
    v.mv  = mv;
    v.sel = sel;
    v.bk  = bk;
    v.rep = rep;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {up, down, left, right, a, b} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [5:0] in);
    reset = 1'b0;
    {up, down, left, right, a, b} = in;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  int   mv_s_cnt, mv_w_cnt;
  logic rep_seen;
  int   exp_col;

  initial begin
    // tap right, hold down 20 cycles, then a/b press and hold
    add(1, K_NONE,  0, 0, 0, 0, 0, 0);
    add(1, K_RT,    0, 0, 0, 0, 0, 0);
    add(1, K_NONE,  0, 1, 1, 0, 0, 0);
    add(2, K_NONE,  0, 1, 0, 0, 0, 0);
    add(1, K_DN,    0, 1, 0, 0, 0, 0);
    add(1, K_DN,    1, 1, 1, 0, 0, 0);
    add(7, K_DN,    1, 1, 0, 0, 0, 0);
    add(1, K_DN,    2, 1, 1, 0, 0, 1);
    add(2, K_DN,    2, 1, 0, 0, 0, 1);
    add(1, K_DN,    0, 1, 1, 0, 0, 1);
    add(2, K_DN,    0, 1, 0, 0, 0, 1);
    add(1, K_DN,    1, 1, 1, 0, 0, 1);
    add(2, K_DN,    1, 1, 0, 0, 0, 1);
    add(1, K_DN,    2, 1, 1, 0, 0, 1);
    add(1, K_DN,    2, 1, 0, 0, 0, 1);
    add(1, K_NONE,  2, 1, 0, 0, 0, 1);
    add(2, K_NONE,  2, 1, 0, 0, 0, 0);
    add(1, K_A|K_B, 2, 1, 0, 0, 0, 0);
    add(1, K_A,     2, 1, 0, 1, 1, 0);
    add(2, K_A,     2, 1, 0, 0, 0, 0);
    add(1, K_B,     2, 1, 0, 0, 0, 0);
    add(1, K_NONE,  2, 1, 0, 0, 1, 0);
    add(2, K_NONE,  2, 1, 0, 0, 0, 0);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.row", row, 0);
    chk("rst.col", col, 0);
    chk("rst.move", move_tick, 0);
    chk("rst.rep", repeating, 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      chk($sformatf("tbl%0d.row", i), row, tbl[i].row);
      chk($sformatf("tbl%0d.col", i), col, tbl[i].col);
      chk($sformatf("tbl%0d.move", i), move_tick, tbl[i].mv);
      chk($sformatf("tbl%0d.sel", i), sel_tick, tbl[i].sel);
      chk($sformatf("tbl%0d.back", i), back_tick, tbl[i].bk);
      chk($sformatf("tbl%0d.rep", i), repeating, tbl[i].rep);
    end

    // saturating instance at col 0 holding left; wrapping instance alongside
    do_reset(K_NONE);
    mv_s_cnt = 0;
    mv_w_cnt = 0;
    rep_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(i < 15 ? K_LF : K_NONE);
      chk($sformatf("sat%0d.col", i), col_s, 0);
      if (move_s)    mv_s_cnt++;
      if (move_tick) mv_w_cnt++;
      if (rep_s)     rep_seen = 1'b1;
    end
    chk("sat.moves", mv_s_cnt, 0);
    chk("sat.rep_seen", rep_seen, 1);
    chk("sat.rep_end", rep_s, 0);
    chk("wrapleft.col", col, 1);
    chk("wrapleft.moves", mv_w_cnt, 4);

    // up held, down pressed meanwhile, up released: down only after IDLE
    do_reset(K_NONE);
    for (int i = 0; i < 12; i++) begin
      drive(i < 3 ? K_UP : (i < 6 ? (K_UP | K_DN) : (i < 9 ? K_DN : K_NONE)));
      chk($sformatf("prio%0d.row", i), row, (i >= 1 && i < 8) ? 2 : 0);
      chk($sformatf("prio%0d.move", i), move_tick, (i == 1 || i == 8));
    end

    // a and b together while right repeats
    do_reset(K_NONE);
    for (int i = 0; i < 19; i++) begin
      drive((i < 16 ? K_RT : K_NONE) | (i == 4 ? (K_A | K_B) : K_NONE));
      exp_col = (i < 1) ? 0 : (i < 9) ? 1 : (i < 12) ? 2 : (i < 15) ? 3 : 4;
      chk($sformatf("ab%0d.col", i), col, exp_col);
      chk($sformatf("ab%0d.move", i), move_tick, (i == 1 || i == 9 || i == 12 || i == 15));
      chk($sformatf("ab%0d.sel", i), sel_tick, (i == 5));
      chk($sformatf("ab%0d.back", i), back_tick, (i == 5));
      chk($sformatf("ab%0d.rep", i), repeating, (i >= 9 && i < 17));
    end

    // key held through reset release counts as a fresh press
    do_reset(K_DN);
    drive(K_DN);
    chk("relhold0.row", row, 0);
    drive(K_DN);
    chk("relhold1.row", row, 1);
    chk("relhold1.move", move_tick, 1);
    drive(K_NONE);
    chk("relhold2.move", move_tick, 0);
    drive(K_NONE);
    chk("relhold3.row", row, 1);

    // reset asserted mid-REPEAT at row 2, col 3
    do_reset(K_NONE);
    drive(K_UP);
    drive(K_NONE);
    drive(K_NONE);
    for (int i = 0; i < 13; i++) drive(K_RT);
    chk("mid.row", row, 2);
    chk("mid.col", col, 3);
    chk("mid.rep", repeating, 1);
    chk("mid.move", move_tick, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async.row", row, 0);
    chk("async.col", col, 0);
    chk("async.move", move_tick, 0);
    chk("async.sel", sel_tick, 0);
    chk("async.back", back_tick, 0);
    chk("async.rep", repeating, 0);
    {up, down, left, right, a, b} = K_NONE;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(K_NONE);
      chk($sformatf("post%0d.move", i), move_tick, 0);
      chk($sformatf("post%0d.pos", i), {row, col}, 0);
      chk($sformatf("post%0d.rep", i), repeating, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
